// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit period, data width and receiver FSM encoding.
package uart_pkg;

  localparam int unsigned CLK_PER_BIT_DEF = 20;
  localparam int unsigned DATA_W          = 8;
  localparam int unsigned IDX_W           = 3;
  localparam int unsigned CNT_W           = 16;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_START     = ST_START,
    S_DATA      = ST_DATA,
    S_STOP      = ST_STOP,
    S_WAIT_IDLE = ST_WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pin; both flops reset to RESET_VAL.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the async input through two flops to settle metastability.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling, valid/ack byte handshake.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = CLK_PER_BIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic [DATA_W-1:0] data_out,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned    HALF      = CLK_PER_BIT / 2;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

  logic              rx_s;
  rx_state_e         state;
  rx_state_e         state_nxt;
  logic [CNT_W-1:0]  clk_counter;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shift_reg;
  logic              sample_bit;
  logic              deliver;
  logic              stop_bad;

  uart_rx_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus per-cycle strobes for sampling, delivery and framing errors.
  always_comb begin
    state_nxt  = state;
    sample_bit = 1'b0;
    deliver    = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) state_nxt = S_START;
      end
      S_START: begin
        if (clk_counter == HALF_LAST) state_nxt = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (clk_counter == BIT_LAST) begin
          sample_bit = 1'b1;
          if (bit_idx == IDX_LAST) state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (clk_counter == BIT_LAST) begin
          if (rx_s) begin
            deliver   = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            stop_bad  = 1'b1;
            state_nxt = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bit-period counter: restarts on every state change and every captured data bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_counter <= '0;
    end else if ((state_nxt != state) || sample_bit ||
                 (state == S_IDLE) || (state == S_WAIT_IDLE)) begin
      clk_counter <= '0;
    end else begin
      clk_counter <= clk_counter + CNT_W'(1);
    end
  end

  // Data capture; bit_idx naturally wraps 7->0 on the capture that leaves DATA.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_idx   <= '0;
      shift_reg <= '0;
    end else if (sample_bit) begin
      shift_reg[bit_idx] <= rx_s;
      bit_idx            <= bit_idx + IDX_W'(1);
    end
  end

  // Output handshake: delivery beats a same-cycle ack; overrun only if the old byte is unacked.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out  <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= deliver && rx_valid && !rx_ack;
      busy      <= (state_nxt != S_IDLE);
      if (deliver) begin
        data_out <= shift_reg;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 20 clocks per bit.
module tb_uart_rx;

  localparam int CPB = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       rx_ack;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] got[$];

  uart_rx #(.CLK_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data_out  (data_out),
    .rx_valid  (rx_valid),
    .rx_ack    (rx_ack),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Count high cycles of the one-cycle pulse outputs.
  always @(negedge clk) begin
    fe_cnt <= fe_cnt + int'(frame_err);
    ov_cnt <= ov_cnt + int'(overrun);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Start bit plus eight data bits; returns just after edge E0+179.
  task automatic drive_bits(input logic [7:0] d);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(CPB);
    end
  endtask

  task automatic send_frame(input logic [7:0] d);
    drive_bits(d);
    rx = 1'b1;
    tick(CPB);
  endtask

  initial begin
    reset  = 1'b1;
    rx     = 1'b1;
    rx_ack = 1'b0;
    tick(4);
    chk("rst_data", 32'(data_out), 32'h00);
    chk("rst_valid", 32'(rx_valid), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    tick(3);

    // Good frame 0xA5 with exact delivery latency of 192 edges from E0.
    drive_bits(8'hA5);
    chk("a5_busy_mid", 32'(busy), 32'h1);
    rx = 1'b1;
    tick(12);
    chk("a5_valid_e191", 32'(rx_valid), 32'h0);
    chk("a5_busy_e191", 32'(busy), 32'h1);
    tick(1);
    chk("a5_valid_e192", 32'(rx_valid), 32'h1);
    chk("a5_data", 32'(data_out), 32'hA5);
    chk("a5_busy_e192", 32'(busy), 32'h0);
    tick(7);
    tick(5);
    chk("a5_ferr_cnt", 32'(fe_cnt), 32'd0);
    chk("a5_ovr_cnt", 32'(ov_cnt), 32'd0);

    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    chk("ack_clears", 32'(rx_valid), 32'h0);
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    chk("ack_idle_ignored", 32'(rx_valid), 32'h0);

    // False start: 3-cycle glitch, START aborts at E0+12.
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(3);
    chk("glitch_busy", 32'(busy), 32'h1);
    tick(10);
    chk("glitch_idle", 32'(busy), 32'h0);
    chk("glitch_valid", 32'(rx_valid), 32'h0);
    chk("glitch_data", 32'(data_out), 32'hA5);
    chk("glitch_flags", 32'(fe_cnt + ov_cnt), 32'd0);

    // Framing error: 0x3C with stop bit held low for 40 cycles.
    drive_bits(8'h3C);
    rx = 1'b0;
    tick(13);
    chk("fe_pulse", 32'(frame_err), 32'h1);
    chk("fe_data_kept", 32'(data_out), 32'hA5);
    chk("fe_valid", 32'(rx_valid), 32'h0);
    tick(1);
    chk("fe_pulse_end", 32'(frame_err), 32'h0);
    tick(26);
    chk("fe_wait_busy", 32'(busy), 32'h1);
    rx = 1'b1;
    tick(1);
    chk("fe_wait_still", 32'(busy), 32'h1);
    tick(2);
    chk("fe_wait_left", 32'(busy), 32'h0);
    chk("fe_cnt", 32'(fe_cnt), 32'd1);
    tick(5);

    // Overrun: 0x11 then 0x22 back-to-back with no ack.
    send_frame(8'h11);
    chk("ovr_first_data", 32'(data_out), 32'h11);
    drive_bits(8'h22);
    rx = 1'b1;
    tick(13);
    chk("ovr_pulse", 32'(overrun), 32'h1);
    chk("ovr_data", 32'(data_out), 32'h22);
    chk("ovr_valid", 32'(rx_valid), 32'h1);
    tick(1);
    chk("ovr_pulse_end", 32'(overrun), 32'h0);
    tick(6);
    chk("ovr_cnt", 32'(ov_cnt), 32'd1);

    // Ack exactly on the delivery edge: new byte wins, no overrun.
    drive_bits(8'h44);
    rx = 1'b1;
    tick(12);
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    chk("coll_ovr", 32'(overrun), 32'h0);
    chk("coll_valid", 32'(rx_valid), 32'h1);
    chk("coll_data", 32'(data_out), 32'h44);
    tick(7);
    chk("coll_ovr_cnt", 32'(ov_cnt), 32'd1);

    // Reset in the middle of bit 4 of 0xFF.
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(4 * CPB + 10);
    reset = 1'b1;
    tick(1);
    chk("mrst_data", 32'(data_out), 32'h00);
    chk("mrst_valid", 32'(rx_valid), 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_flags", 32'({frame_err, overrun}), 32'h0);
    reset = 1'b0;
    tick(150);
    chk("mrst_no_retrigger", 32'(busy), 32'h0);
    send_frame(8'h5A);
    chk("mrst_5a_data", 32'(data_out), 32'h5A);
    chk("mrst_5a_valid", 32'(rx_valid), 32'h1);
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    tick(3);

    // Streaming three frames with no gap, each acked one cycle after valid.
    fork
      begin
        send_frame(8'h00);
        send_frame(8'hFF);
        send_frame(8'h55);
      end
      begin
        repeat (3 * 10 * CPB + 10) begin
          tick(1);
          if (rx_valid && !rx_ack) begin
            got.push_back(data_out);
            rx_ack = 1'b1;
          end else begin
            rx_ack = 1'b0;
          end
        end
        rx_ack = 1'b0;
      end
    join
    chk("stream_count", 32'(got.size()), 32'd3);
    while (got.size() < 3) got.push_back(8'hxx);
    chk("stream_b0", 32'(got[0]), 32'h00);
    chk("stream_b1", 32'(got[1]), 32'hFF);
    chk("stream_b2", 32'(got[2]), 32'h55);
    chk("stream_valid", 32'(rx_valid), 32'h0);
    chk("stream_ferr", 32'(fe_cnt), 32'd1);
    chk("stream_ovr", 32'(ov_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver, 8N1, LSB first, the receive-side counterpart of the SoC's UART transmitter. It samples the asynchronous `rx` pin through a two-flop synchronizer and checks each bit at mid-bit. Each byte is presented on a valid/ack handshake to the AXI UART peripheral register logic. Framing errors, overruns and false starts are detected in hardware.

## Interface
- `CLK_PER_BIT`, 20: clock cycles per bit, legal range ≥ 4. Same value as the transmitter's bit period. `HALF = CLK_PER_BIT/2` (integer division).
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  reset, synchronous, active-high.
- `rx`  in  1  asynchronous serial input, idle high.
- `data_out`  out  8  last received byte; held until the next good byte.
- `rx_valid`  out  1  byte available; sticky until acknowledged.
- `rx_ack`  in  1  consumer acknowledge; clears `rx_valid`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: good byte delivered while `rx_valid` was still set and not being acked.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **Synchronizer:** 2 flops, reset to 1. `rx_s` is the second flop. All FSM decisions use `rx_s` only.
- **Counter and bit index:** 16-bit `clk_counter` clears on every state change. 3-bit `bit_idx` wraps 7→0 only on leaving DATA.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_IDLE. The state is registered.
- **IDLE:** if `rx_s==0`, go to START with counter at 0.
- **START:** at `clk_counter==HALF-1`, recheck `rx_s`.
  - `rx_s==0`: go to DATA with counter at 0.
  - `rx_s==1`: false start (glitch). Return to IDLE with no flags.
- **DATA:** at `clk_counter==CLK_PER_BIT-1`, do `shift_reg[bit_idx] <= rx_s` and increment `bit_idx`. After bit 7, go to STOP.
- **STOP:** at `clk_counter==CLK_PER_BIT-1`, sample `rx_s`.
  - `rx_s==1`: deliver the byte and go to IDLE.
  - `rx_s==0`: pulse `frame_err`, discard the byte (`data_out` and `rx_valid` unchanged), go to WAIT_IDLE.
- **WAIT_IDLE:** stay until `rx_s==1`, then go to IDLE. A line break therefore never re-triggers reception.
- **Delivery** (all updates on the same edge):
  - `data_out <= shift_reg` and `rx_valid <= 1`.
  - If `rx_valid==1 && !rx_ack`, also pulse `overrun`. The new byte overwrites the old one.
- **Ack:**
  - `rx_ack` while `rx_valid==1` clears `rx_valid` on the next edge.
  - `rx_ack` while `rx_valid==0` is ignored.
  - Ack in the same cycle as delivery: the new byte wins, `rx_valid` stays 1, no overrun.
- **Reset (any time, including mid-frame):** go to IDLE. Counter, `bit_idx` and `shift_reg` clear, synchronizer flops go to 1. Outputs: `data_out=0`, `rx_valid=0`, `frame_err=0`, `overrun=0`, `busy=0`. Reception restarts only on a new falling edge after reset is released.

## Timing
- Let E0 be the first clock edge at which `rx` is sampled low.
  - `rx_s` falls at E1.
  - START is entered at E2.
  - DATA is entered at E2+HALF.
- Data bit n (0..7) is captured at edge E2+HALF+(n+1)·CLK_PER_BIT. That capture reflects `rx` at E0+HALF+(n+1)·CLK_PER_BIT, which is mid-bit.
- Stop is sampled at E2+HALF+9·CLK_PER_BIT. `rx_valid`, `frame_err` and `overrun` update on that edge.
  - Latency from E0 to `rx_valid` = HALF + 9·CLK_PER_BIT + 2 cycles, which is 192 at the default.
- `frame_err` and `overrun` are high for exactly one cycle.
- Back-to-back frames with no idle gap:
  - IDLE is re-entered HALF cycles before the nominal end of the stop bit.
  - The next start bit is therefore detected without loss.
  - Tolerated baud mismatch is ±~4%.
- `busy` rises at E2 and falls on the edge that returns the FSM to IDLE.

## Structure
- **Shared package `uart_pkg`** (used by both the transmitter and this block):
  - the default `CLK_PER_BIT` value;
  - the FSM state encoding localparams;
  - the data width (8).
- **Sub-module:** `uart_rx_sync`, a 2-flop synchronizer with parameterized reset value 1.
- **`uart_rx` itself:** FSM, counter, shift register and output/handshake logic.

## Test plan
- **Good frame:** reset, then drive 0xA5 8N1 at 20 clk/bit, no ack → `data_out=0xA5`, `rx_valid` rises at E0+192, no `frame_err`, `busy` low afterwards.
- **False start:** a 3-cycle low glitch on `rx` → FSM returns to IDLE after START, `rx_valid` stays 0, no flags.
- **Framing error:** 0x3C with stop bit held low for 40 cycles → `frame_err` 1-cycle pulse, `data_out` keeps its prior value, FSM leaves WAIT_IDLE only after `rx` returns high.
- **Overrun / ack collision:** 0x11 then 0x22 back-to-back, no ack → `overrun` pulses at the second stop, `data_out=0x22`. Repeat with `rx_ack` on the delivery cycle → no overrun, `rx_valid` stays 1.
- **Reset mid-frame:** assert `reset` during bit 4 of 0xFF → all outputs 0 next edge. Then send 0x5A → `data_out=0x5A`, `rx_valid=1`.
- **Streaming:** 0x00, 0xFF, 0x55 with no idle gap, each acked one cycle after `rx_valid` → three correct bytes, no flags.
